// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: computes A - B - Bin one bit per clock, LSB first.
// Define SUB_OVERFLOW_EN to add the signed-overflow output ovf.
module bit_serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic             accept;
  logic             last;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic [WIDTH-1:0] d_full;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             d_bit;
  logic             br_nxt;
`ifdef SUB_OVERFLOW_EN
  logic             a_msb;
  logic             b_msb;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One-bit full subtractor on the current LSBs of the operand shifters.
  assign d_bit  = a_sh[0] ^ b_sh[0] ^ br;
  assign br_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
  assign d_full = {d_bit, d_sh[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      d_sh  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      D     <= '0;
      Bout  <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      a_sh  <= A;
      b_sh  <= B;
      br    <= Bin;
      cnt   <= '0;
`ifdef SUB_OVERFLOW_EN
      a_msb <= A[WIDTH-1];
      b_msb <= B[WIDTH-1];
`endif
    end else if (state == SHIFT) begin
      a_sh <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh <= {1'b0, b_sh[WIDTH-1:1]};
      d_sh <= d_full;
      br   <= br_nxt;
      // Counter parks at the last index rather than wrapping.
      if (!last) cnt <= cnt + CW'(1);
      if (last) begin
        D    <= d_full;
        Bout <= br_nxt;
`ifdef SUB_OVERFLOW_EN
        ovf  <= (a_msb != b_msb) & (d_bit != a_msb);
`endif
      end
    end
  end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Scoreboard bench for bit_serial_subtractor (WIDTH=4) with directed vectors.
module tb_bit_serial_subtractor;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;
`ifdef SUB_OVERFLOW_EN
  logic             ovf;
`endif

  bit_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (a),
    .B    (b),
    .Bin  (bin),
    .busy (busy),
    .done (done),
    .D    (d),
    .Bout (bout)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf  (ovf)
`endif
  );

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;
    int               due;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("D", int'(d), int'(e.d));
        chk("Bout", int'(bout), int'(e.bout));
        chk("done_cycle", cyc, e.due);
`ifdef SUB_OVERFLOW_EN
        chk("ovf", int'(ovf), int'(e.ovf));
`endif
      end
    end
  end

  // Drive operands with start high; returns 1 ns after the accepting edge.
  task automatic accept(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bi,
                        input logic [WIDTH-1:0] ed, input logic eb, input logic eo, input bit push);
    exp_t e;
    a = av;
    b = bv;
    bin = bi;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (push) begin
      e.d = ed;
      e.bout = eb;
      e.ovf = eo;
      e.due = cyc + WIDTH;
      sb.push_back(e);
    end
  endtask

  task automatic check_busy(input string name, input int n, input logic exp);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(name, int'(busy), int'(exp));
    end
  endtask

  task automatic single(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bi,
                        input logic [WIDTH-1:0] ed, input logic eb, input logic eo);
    accept(av, bv, bi, ed, eb, eo, 1);
    start = 1'b0;
    check_busy("busy_shift", WIDTH, 1'b1);
    check_busy("busy_done", 1, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_D", int'(d), 0);
    chk("rst_Bout", int'(bout), 0);
    @(posedge clk);
    #1;

    //       A   B  Bin  D  Bout ovf
    single(9,  3,  0,  6,  0,  1);
    single(3,  9,  0,  10, 1,  1);
    single(0,  0,  1,  15, 1,  0);
    single(8,  1,  0,  7,  0,  1);
    single(7,  15, 0,  8,  1,  1);
    single(6,  2,  0,  4,  0,  0);

    // start held high: second operation accepted in the DONE cycle
    accept(5, 2, 0, 3, 0, 0, 1);
    a = 1;
    b = 1;
    check_busy("b2b_busy1", WIDTH, 1'b1);
    check_busy("b2b_done1", 1, 1'b0);
    accept(1, 1, 0, 0, 0, 0, 1);
    start = 1'b0;
    check_busy("b2b_busy2", WIDTH, 1'b1);
    check_busy("b2b_done2", 1, 1'b0);
    @(posedge clk);
    #1;

    // operand changes and start pulses during SHIFT are ignored
    accept(5, 12, 1, 8, 1, 1, 1);
    a = 0;
    b = 15;
    bin = 1'b1;
    check_busy("dist_busy_a", 2, 1'b1);
    start = 1'b0;
    check_busy("dist_busy_b", WIDTH - 2, 1'b1);
    check_busy("dist_done", 1, 1'b0);
    @(posedge clk);
    #1;

    // reset during the second SHIFT cycle aborts with no done pulse
    accept(14, 3, 0, 0, 0, 0, 0);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_D", int'(d), 0);
    chk("abort_Bout", int'(bout), 0);
`ifdef SUB_OVERFLOW_EN
    chk("abort_ovf", int'(ovf), 0);
`endif
    repeat (6) @(negedge clk);
    chk("abort_idle_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    single(7, 2, 0, 5, 0, 0);

    repeat (4) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
